// File: rtl/checkpoint_perf_monitor.sv
// Debounces the firmware checkpoint bus, times START_CODE -> STOP_CODE in clock
// cycles and reports cycles/kilocycles/timeout through a valid/ready result port.
module checkpoint_perf_monitor #(
  parameter logic [15:0] START_CODE    = 16'hA000,
  parameter logic [15:0] STOP_CODE     = 16'hAB00,
  parameter int          STABLE_CYCLES = 4,
  parameter int          KCYCLE_DIV    = 1000,
  parameter int          TIMEOUT_K     = 150,
  parameter int          CNT_W         = 32
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             enable,
  input  logic [15:0]      checkbits,
  output logic             busy,
  output logic [CNT_W-1:0] live_kcycles,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             result_timeout,
  output logic [CNT_W-1:0] result_cycles,
  output logic [CNT_W-1:0] result_kcycles,
  output logic [1:0]       dbg_state
);

  // Result handshake: result_valid stays high and the result fields stay
  // constant until the cycle in which result_valid && result_ready; the
  // transfer happens on that rising edge and result_valid drops next cycle.

  localparam int SCW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [15:0]      last;
  logic [SCW-1:0]   stable_cnt;
  logic             acc;
  logic             is_start, is_stop;
  logic             load_start, capture, cap_timeout;
  logic [CNT_W-1:0] cyc, sub, kcyc;
  logic             timeout_hit;

  // acc is registered so it lands exactly STABLE_CYCLES after the value first
  // appeared; it fires when the count reaches its saturation value, so only once.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      last       <= '0;
      stable_cnt <= '0;
      acc        <= 1'b0;
    end else begin
      acc <= (checkbits == last) && (stable_cnt == SCW'(STABLE_CYCLES - 2));
      if (checkbits != last) begin
        last       <= checkbits;
        stable_cnt <= '0;
      end else if (stable_cnt != SCW'(STABLE_CYCLES - 1)) begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

  assign is_start    = acc && (last == START_CODE);
  assign is_stop     = acc && (last == STOP_CODE);
  assign timeout_hit = (kcyc == CNT_W'(TIMEOUT_K));

  always_ff @(posedge clock) begin
    if (!resetb) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next  = state;
    load_start  = 1'b0;
    capture     = 1'b0;
    cap_timeout = 1'b0;
    if (!enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_start) begin
            state_next = ST_RUN;
            load_start = 1'b1;
          end
        end
        ST_RUN: begin
          // A stop in the same cycle as the timeout wins; a repeated start restarts.
          if (is_stop) begin
            state_next = ST_REPORT;
            capture    = 1'b1;
          end else if (is_start) begin
            load_start = 1'b1;
          end else if (timeout_hit) begin
            state_next  = ST_REPORT;
            capture     = 1'b1;
            cap_timeout = 1'b1;
          end
        end
        ST_REPORT: begin
          if (result_ready) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // sub tracks cyc mod KCYCLE_DIV so kcyc stays floor(cyc / KCYCLE_DIV).
  always_ff @(posedge clock) begin
    if (!resetb || !enable) begin
      cyc  <= '0;
      sub  <= '0;
      kcyc <= '0;
    end else if (load_start) begin
      cyc  <= CNT_W'(1);
      sub  <= CNT_W'(1);
      kcyc <= '0;
    end else if (state == ST_RUN && !capture) begin
      if (cyc != '1) cyc <= cyc + 1'b1;
      if (sub == CNT_W'(KCYCLE_DIV - 1)) begin
        sub  <= '0;
        kcyc <= kcyc + 1'b1;
      end else begin
        sub <= sub + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      result_cycles  <= '0;
      result_kcycles <= '0;
      result_timeout <= 1'b0;
    end else if (capture) begin
      result_cycles  <= cyc;
      result_kcycles <= kcyc;
      result_timeout <= cap_timeout;
    end
  end

  assign busy         = (state == ST_RUN);
  assign result_valid = (state == ST_REPORT);
  assign live_kcycles = kcyc;
  assign dbg_state    = state;

endmodule

// File: tb/tb_checkpoint_perf_monitor.sv
// Directed bench for checkpoint_perf_monitor: filter acceptance, timing,
// restart, timeout, backpressure, reset and enable behaviour.
module tb_checkpoint_perf_monitor;

  localparam int CNT_W     = 32;
  localparam int TIMEOUT_K = 20;  // shortened so the timeout run stays brief

  logic             clock = 1'b0;
  logic             resetb;
  logic             enable;
  logic [15:0]      checkbits;
  logic             busy;
  logic [CNT_W-1:0] live_kcycles;
  logic             result_valid;
  logic             result_ready;
  logic             result_timeout;
  logic [CNT_W-1:0] result_cycles;
  logic [CNT_W-1:0] result_kcycles;
  logic [1:0]       dbg_state;

  int checks   = 0;
  int failures = 0;
  int cycle_no = 0;

  checkpoint_perf_monitor #(.TIMEOUT_K(TIMEOUT_K)) dut (
    .clock(clock), .resetb(resetb), .enable(enable), .checkbits(checkbits),
    .busy(busy), .live_kcycles(live_kcycles), .result_valid(result_valid),
    .result_ready(result_ready), .result_timeout(result_timeout),
    .result_cycles(result_cycles), .result_kcycles(result_kcycles),
    .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle_no <= cycle_no + 1;

  // Advance n cycles; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(input int budget, output bit ok, output int at_cycle);
    ok = 1'b0;
    at_cycle = 0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (result_valid === 1'b1) begin
        ok = 1'b1;
        at_cycle = cycle_no;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetb = 1'b0; enable = 1'b1; checkbits = 16'h0000; result_ready = 1'b1;
    step(3);
    checks++;
    if ({busy, result_valid, result_timeout} !== 3'b000 || live_kcycles !== 0 ||
        result_cycles !== 0 || result_kcycles !== 0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b valid=%b to=%b live=%0d cyc=%0d kc=%0d st=%0d required all 0",
               busy, result_valid, result_timeout, live_kcycles, result_cycles, result_kcycles, dbg_state);
    end
    resetb = 1'b1;
    step(8);
  endtask

  task automatic test_basic();
    bit ok; int at;
    checkbits = 16'hA000;
    step(1000);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL basic_busy: busy=%b required 1", busy);
    end
    step(1500);
    checkbits = 16'hAB00;
    wait_valid(20, ok, at);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL basic_valid: result_valid never seen, required 1");
    end else begin
      checks++;
      if (result_cycles !== 2500 || result_kcycles !== 2 || result_timeout !== 1'b0) begin
        failures++;
        $display("FAIL basic_result: cycles=%0d kcycles=%0d timeout=%b required 2500 2 0",
                 result_cycles, result_kcycles, result_timeout);
      end
    end
    step(1);
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || live_kcycles !== 2) begin
      failures++;
      $display("FAIL basic_after: valid=%b busy=%b live=%0d required 0 0 2",
               result_valid, busy, live_kcycles);
    end
    checkbits = 16'h0000;
    step(8);
  endtask

  task automatic test_glitch();
    bit saw = 1'b0;
    checkbits = 16'hA000;
    step(3);
    checkbits = 16'h0000;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (busy !== 1'b0 || result_valid !== 1'b0) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) begin
      failures++; $display("FAIL glitch_ignored: activity seen=%b required 0", saw);
    end
  endtask

  task automatic test_timeout();
    bit ok; int at; int first_busy = -1;
    checkbits = 16'hA000;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (busy === 1'b1) begin first_busy = cycle_no; break; end
    end
    checks++;
    if (first_busy < 0) begin
      failures++; $display("FAIL timeout_start: busy never rose, required 1");
    end
    wait_valid(TIMEOUT_K * 1000 + 50, ok, at);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL timeout_valid: result_valid never seen, required 1");
    end else begin
      checks++;
      if (at - first_busy !== TIMEOUT_K * 1000) begin
        failures++;
        $display("FAIL timeout_latency: report after %0d cycles required %0d",
                 at - first_busy, TIMEOUT_K * 1000);
      end
      checks++;
      if (result_cycles !== TIMEOUT_K * 1000 || result_kcycles !== TIMEOUT_K || result_timeout !== 1'b1) begin
        failures++;
        $display("FAIL timeout_result: cycles=%0d kcycles=%0d timeout=%b required %0d %0d 1",
                 result_cycles, result_kcycles, result_timeout, TIMEOUT_K * 1000, TIMEOUT_K);
      end
    end
    step(10);
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      failures++; $display("FAIL timeout_no_rerun: busy=%b valid=%b required 0 0", busy, result_valid);
    end
    checkbits = 16'h0000;
    step(8);
  endtask

  task automatic test_restart();
    bit ok; int at;
    checkbits = 16'hA000;
    step(100);
    checkbits = 16'h0000;
    step(500);
    checkbits = 16'hA000;
    step(1200);
    checkbits = 16'hAB00;
    wait_valid(20, ok, at);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL restart_valid: result_valid never seen, required 1");
    end else begin
      checks++;
      if (result_cycles !== 1200 || result_kcycles !== 1 || result_timeout !== 1'b0) begin
        failures++;
        $display("FAIL restart_result: cycles=%0d kcycles=%0d timeout=%b required 1200 1 0",
                 result_cycles, result_kcycles, result_timeout);
      end
    end
    checkbits = 16'h0000;
    step(8);
  endtask

  task automatic test_back_to_back();
    bit ok; int at;
    result_ready = 1'b0;
    checkbits = 16'hA000;
    step(300);
    checkbits = 16'hAB00;
    wait_valid(20, ok, at);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL hold_valid: result_valid never seen, required 1");
    end
    for (int i = 0; i < 20; i++) begin
      if (i == 6)  checkbits = 16'hA000;
      if (i == 12) checkbits = 16'hAB00;
      step(1);
      checks++;
      if (result_valid !== 1'b1 || busy !== 1'b0 || result_cycles !== 300 ||
          result_kcycles !== 0 || result_timeout !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable[%0d]: valid=%b busy=%b cycles=%0d kc=%0d to=%b required 1 0 300 0 0",
                 i, result_valid, busy, result_cycles, result_kcycles, result_timeout);
      end
    end
    result_ready = 1'b1;
    step(1);
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL hold_release: valid=%b busy=%b st=%0d required 0 0 0", result_valid, busy, dbg_state);
    end
    checkbits = 16'h0000;
    step(8);
  endtask

  task automatic test_mid_reset();
    bit saw = 1'b0;
    checkbits = 16'hA000;
    step(505);
    resetb = 1'b0;
    step(1);
    resetb = 1'b1;
    checkbits = 16'hAB00;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (busy !== 1'b0 || result_valid !== 1'b0) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0 || live_kcycles !== 0) begin
      failures++;
      $display("FAIL mid_reset: activity=%b live=%0d required 0 0", saw, live_kcycles);
    end
    checkbits = 16'h0000;
    step(8);
  endtask

  task automatic test_enable();
    checkbits = 16'hA000;
    step(1500);
    checks++;
    if (busy !== 1'b1 || live_kcycles !== 1) begin
      failures++; $display("FAIL enable_run: busy=%b live=%0d required 1 1", busy, live_kcycles);
    end
    enable = 1'b0;
    step(1);
    checks++;
    if (busy !== 1'b0 || live_kcycles !== 0 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL enable_off: busy=%b live=%0d valid=%b required 0 0 0", busy, live_kcycles, result_valid);
    end
    enable = 1'b1;
    step(10);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL enable_no_restart: busy=%b required 0", busy);
    end
    checkbits = 16'h0000;
    step(8);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_timeout();
    test_restart();
    test_back_to_back();
    test_mid_reset();
    test_enable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
